batalha_naval_core: RTL
=======================

# batalha_naval_core

Parametrised game core for the naval-battle board: owns ship-placement and attack grids of ROWS×COLS cells, a three-phase game FSM, shot/hit counters with win/lose detection, and the column-scanned LED-matrix and RGB hit/miss drivers. It sits between the board inputs (switches, debounced confirm button, preset ship map) and the matrix/RGB/7-segment outputs. It generalises the fixed 7×5 position/attack datapath: grid size, shot limit and scan rate are parameters, and it adds repeat-shot rejection, coordinate range checks and end-of-game handling.

## Interface
- ROWS, 7, grid rows (matrix lines), 2..16
- COLS, 5, grid columns (matrix columns), 2..16
- SHOT_LIMIT, 15, valid shots allowed before loss, ≥1
- SCAN_DIV, 1000, clk cycles per matrix column step, ≥1
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  reset, synchronous, active-high
- confirm  in  1  debounced confirm button level, active-high
- ship_map_in  in  ROWS*COLS  preset ship layout, cell (r,c) at bit r*COLS+c, 1 = ship
- at_row  in  RW=$clog2(ROWS)  attack row coordinate
- at_col  in  CW=$clog2(COLS)  attack column coordinate
- m_col  out  COLS  one-hot active-high column select
- m_line  out  ROWS  line data for selected column, m_line[r] = cell (r, scan column)
- rgb_r  out  1  miss / lose indicator
- rgb_g  out  1  hit / win indicator
- phase  out  2  00 POS, 01 ATK, 10 END
- shots  out  $clog2(SHOT_LIMIT+1)  valid shots fired
- hits  out  $clog2(ROWS*COLS+1)  ship cells hit
- win  out  1  high in END when all ship cells hit
- reject  out  1  one-cycle pulse on rejected confirm

## Operation
- Confirm event: confirm=1 at current edge and confirm_q=0 (confirm_q = previous sample). Level holding never repeats an event.
- POS: m_line shows live ship_map_in. Event: if ship_map_in nonzero, load ship register, load ship_total = popcount(ship_map_in), go ATK; if zero, pulse reject, stay POS.
- ATK: m_line shows attack register (1 = cell shot). Event with at_row≥ROWS or at_col≥COLS: reject, no change. Event on already-shot cell: reject, shots unchanged, rgb unchanged. Otherwise set attack bit, shots+1; if ship bit set: hits+1, rgb_g=1, rgb_r=0; else rgb_r=1, rgb_g=0. rgb holds until next valid shot.
- ATK→END on same edge as the shot that makes hits==ship_total (win=1, rgb_g=1, rgb_r=0) or shots==SHOT_LIMIT (win=0, rgb_r=1, rgb_g=0). If both coincide, win takes priority.
- END: m_line shows ship register OR attack register; rgb/win steady. Event: clear attack register, shots, hits, win, rgb; go POS. Ship register retained but unused.
- Scan: divider counts 0..SCAN_DIV-1; on wrap, scan column advances, COLS-1 wraps to 0. m_col[scan]=1 only. Scan runs in all phases, independent of game events.
- Counters saturate by construction (shots never exceeds SHOT_LIMIT, hits never exceeds ship_total).

## Timing
- Reset (clr=1 at an edge): phase=POS, ship/attack registers 0, ship_total=0, shots=0, hits=0, win=0, rgb_r=rgb_g=0, reject=0, divider=0, scan column 0 (m_col=1), confirm_q=1 (button held through reset produces no event). clr overrides any simultaneous event.
- Event-to-effect latency: all updates (phase, registers, counters, rgb, reject) visible immediately after the edge at which the event is detected; reject high exactly one cycle.
- m_col and scan column registered; m_line combinational from registered map and scan column (POS: from ship_map_in).
- Column dwell = SCAN_DIV cycles; full frame = COLS*SCAN_DIV cycles.

## Test plan
- Reset with confirm held high, release and press -> single event only after release; phase 00→01 with nonzero map, ship_total equal to popcount.
- POS confirm with ship_map_in=0 -> reject one cycle, phase stays 00.
- ATK, 7×5, ship at (2,3): shoot (2,3) -> hits=1, shots=1, rgb_g=1; shoot (0,0) -> rgb_r=1, shots=2; reshoot (0,0) -> reject, shots=2; at_row=7 -> reject.
- Single-ship map, hit on first shot -> phase=10, win=1, rgb_g=1; confirm -> phase=00, shots=hits=0, rgb off.
- SHOT_LIMIT=3, three misses -> phase=10, win=0, rgb_r=1; m_line shows ship OR attack per column.
- SCAN_DIV=4, COLS=5 -> m_col steps 00001→00010→…→10000→00001 every 4 cycles, wraps after 20.

Source files
------------

// File: rtl/batalha_naval_core.sv
`default_nettype none
// ============================================================================
// Module   : batalha_naval_core
// Summary  : Naval-battle game core. Holds the ship and attack grids and runs
//            the POS -> ATK -> END game flow. Counts shots and hits, detects
//            win or loss, and drives the column-scanned LED matrix and the
//            RGB hit/miss indicator.
// Revision : 1.0 - initial release
// ============================================================================
module batalha_naval_core #(
  parameter int ROWS       = 7,
  parameter int COLS       = 5,
  parameter int SHOT_LIMIT = 15,
  parameter int SCAN_DIV   = 1000,
  localparam int RW        = $clog2(ROWS),
  localparam int CW        = $clog2(COLS),
  localparam int SW        = $clog2(SHOT_LIMIT + 1),
  localparam int HW        = $clog2(ROWS * COLS + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   confirm,
  input  logic [ROWS*COLS-1:0]   ship_map_in,
  input  logic [RW-1:0]          at_row,
  input  logic [CW-1:0]          at_col,
  output logic [COLS-1:0]        m_col,
  output logic [ROWS-1:0]        m_line,
  output logic                   rgb_r,
  output logic                   rgb_g,
  output logic [1:0]             phase,
  output logic [SW-1:0]          shots,
  output logic [HW-1:0]          hits,
  output logic                   win,
  output logic                   reject
);

  localparam int N  = ROWS * COLS;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    PH_POS = 2'b00,
    PH_ATK = 2'b01,
    PH_END = 2'b10
  } phase_e;

  // Grids are packed [row][col], so the flat bit index is row*COLS+col,
  // which matches the ship_map_in layout directly.
  typedef logic [ROWS-1:0][COLS-1:0] grid_t;

  phase_e           phase_q, phase_d;
  grid_t            ship_q, ship_d;
  grid_t            atk_q, atk_d;
  logic [HW-1:0]    total_q, total_d;
  logic [SW-1:0]    shots_q, shots_d;
  logic [HW-1:0]    hits_q, hits_d;
  logic             win_q, win_d;
  logic             rgb_r_q, rgb_r_d;
  logic             rgb_g_q, rgb_g_d;
  logic             reject_q, reject_d;
  logic             confirm_q, confirm_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    scan_q, scan_d;
  logic [COLS-1:0]  m_col_q, m_col_d;

  logic             evt;
  logic             in_range;
  logic             cell_shot;
  logic             cell_ship;
  logic [HW-1:0]    map_count;
  grid_t            live_map;
  grid_t            disp;

  assign live_map  = ship_map_in;
  assign evt       = confirm & ~confirm_q;
  assign in_range  = ({1'b0, at_row} < (RW + 1)'(ROWS)) &&
                     ({1'b0, at_col} < (CW + 1)'(COLS));
  // Gate the grid lookups so an out-of-range coordinate never matters.
  assign cell_shot = in_range & atk_q[at_row][at_col];
  assign cell_ship = in_range & ship_q[at_row][at_col];

  // Population count of the preset map, latched as the win target.
  always_comb begin
    map_count = '0;
    for (int i = 0; i < N; i++) begin
      map_count = map_count + HW'(ship_map_in[i]);
    end
  end

  // Game FSM next state: placement, attack bookkeeping, end-of-game clear.
  always_comb begin
    phase_d   = phase_q;
    ship_d    = ship_q;
    atk_d     = atk_q;
    total_d   = total_q;
    shots_d   = shots_q;
    hits_d    = hits_q;
    win_d     = win_q;
    rgb_r_d   = rgb_r_q;
    rgb_g_d   = rgb_g_q;
    reject_d  = 1'b0;
    confirm_d = confirm;
    if (evt) begin
      case (phase_q)
        PH_POS: begin
          if (ship_map_in != '0) begin
            ship_d  = ship_map_in;
            total_d = map_count;
            phase_d = PH_ATK;
          end else begin
            reject_d = 1'b1;
          end
        end
        PH_ATK: begin
          if (!in_range || cell_shot) begin
            reject_d = 1'b1;
          end else begin
            atk_d[at_row][at_col] = 1'b1;
            shots_d = shots_q + SW'(1);
            if (cell_ship) begin
              hits_d  = hits_q + HW'(1);
              rgb_g_d = 1'b1;
              rgb_r_d = 1'b0;
            end else begin
              rgb_r_d = 1'b1;
              rgb_g_d = 1'b0;
            end
            // Win is checked first so a final hit on the last allowed
            // shot still counts as a win.
            if (hits_d == total_q) begin
              phase_d = PH_END;
              win_d   = 1'b1;
              rgb_g_d = 1'b1;
              rgb_r_d = 1'b0;
            end else if (shots_d == SW'(SHOT_LIMIT)) begin
              phase_d = PH_END;
              win_d   = 1'b0;
              rgb_r_d = 1'b1;
              rgb_g_d = 1'b0;
            end
          end
        end
        PH_END: begin
          atk_d   = '0;
          shots_d = '0;
          hits_d  = '0;
          win_d   = 1'b0;
          rgb_r_d = 1'b0;
          rgb_g_d = 1'b0;
          phase_d = PH_POS;
        end
        default: phase_d = PH_POS;
      endcase
    end
  end

  // Column scan: divider wraps every SCAN_DIV cycles and steps the column.
  always_comb begin
    div_d   = div_q;
    scan_d  = scan_q;
    m_col_d = m_col_q;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
      if (scan_q == CW'(COLS - 1)) begin
        scan_d  = '0;
        m_col_d = COLS'(1);
      end else begin
        scan_d  = scan_q + CW'(1);
        m_col_d = {m_col_q[COLS-2:0], 1'b0};
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // State registers; confirm history resets high so a held button is ignored.
  always_ff @(posedge clk) begin
    if (clr) begin
      phase_q   <= PH_POS;
      ship_q    <= '0;
      atk_q     <= '0;
      total_q   <= '0;
      shots_q   <= '0;
      hits_q    <= '0;
      win_q     <= 1'b0;
      rgb_r_q   <= 1'b0;
      rgb_g_q   <= 1'b0;
      reject_q  <= 1'b0;
      confirm_q <= 1'b1;
      div_q     <= '0;
      scan_q    <= '0;
      m_col_q   <= COLS'(1);
    end else begin
      phase_q   <= phase_d;
      ship_q    <= ship_d;
      atk_q     <= atk_d;
      total_q   <= total_d;
      shots_q   <= shots_d;
      hits_q    <= hits_d;
      win_q     <= win_d;
      rgb_r_q   <= rgb_r_d;
      rgb_g_q   <= rgb_g_d;
      reject_q  <= reject_d;
      confirm_q <= confirm_d;
      div_q     <= div_d;
      scan_q    <= scan_d;
      m_col_q   <= m_col_d;
    end
  end

  // Matrix line data: live map while placing, shots while attacking,
  // ships overlaid with shots once the game is over.
  always_comb begin
    case (phase_q)
      PH_POS:  disp = live_map;
      PH_ATK:  disp = atk_q;
      PH_END:  disp = ship_q | atk_q;
      default: disp = '0;
    endcase
    for (int r = 0; r < ROWS; r++) begin
      m_line[r] = disp[r][scan_q];
    end
  end

  assign m_col  = m_col_q;
  assign phase  = phase_q;
  assign shots  = shots_q;
  assign hits   = hits_q;
  assign win    = win_q;
  assign rgb_r  = rgb_r_q;
  assign rgb_g  = rgb_g_q;
  assign reject = reject_q;

endmodule
`default_nettype wire
